// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The optional misaligned-redirect trap is controlled by the macro FETCH_ALIGN_TRAP_EN.
package fetch_pkg;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instruction word} pairs sitting between fetch and decode.
// A flush empties it in one cycle and takes precedence over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int QDEPTH = 2,
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [INST_W-1:0] push_word_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [INST_W-1:0] head_word_o
);

  logic [QDEPTH-1:0][ADDR_W-1:0] pc_mem_q;
  logic [QDEPTH-1:0][INST_W-1:0] word_mem_q;
  logic [PTR_W-1:0]              wr_q, wr_d;
  logic [PTR_W-1:0]              rd_q, rd_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          not_empty, full;
  logic                          do_push, do_pop;

  assign not_empty = (cnt_q != '0);
  assign full      = (cnt_q == CNT_W'(QDEPTH));
  assign do_pop    = pop_i && not_empty;
  // A full queue can still take a word when the head leaves on the same edge.
  assign do_push   = push_i && (!full || do_pop);

  // Pointer and occupancy update; flush resets everything to empty.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + PTR_W'(do_push);
      rd_d  = rd_q + PTR_W'(do_pop);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; a flushed push is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_mem_q   <= '0;
      word_mem_q <= '0;
    end else if (do_push && !flush_i) begin
      pc_mem_q[wr_q]   <= push_pc_i;
      word_mem_q[wr_q] <= push_word_i;
    end
  end

  // Head outputs read as zero while the queue is empty.
  assign count_o     = cnt_q;
  assign head_pc_o   = not_empty ? pc_mem_q[rd_q]   : '0;
  assign head_word_o = not_empty ? word_mem_q[rd_q] : '0;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, reads one ROM word per cycle
// into fetch_queue and presents the head to decode over valid/ready.
// Define FETCH_ALIGN_TRAP_EN to trap misaligned redirects (sticky misalign,
// halt); otherwise the low target bits are silently cleared.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              misalign
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  q_count;
  logic              q_full;
  logic              pop;
  logic              push;
  logic              flush;
  logic              trap;

  assign q_full     = (q_count == CNT_W'(QDEPTH));
  assign inst_valid = (q_count != '0);
  assign pop        = inst_valid && inst_ready;
  assign imem_addr  = pc_q;

`ifdef FETCH_ALIGN_TRAP_EN
  logic mis_q, mis_d;

  assign trap = redirect_valid && (redirect_target[1:0] != 2'b00);

  // Misalign is sticky: only reset clears it.
  always_comb mis_d = mis_q | trap;

  // Sticky misalign register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end

  assign misalign = mis_q;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a trapped redirect halts; halt_req beats start; a pending
  // misalign keeps the sequencer parked.
  always_comb begin
    state_d = state_q;
    if (trap) begin
      state_d = HALTED;
    end else begin
      unique case (state_q)
        FETCH: if (halt_req) state_d = HALTED;
        IDLE, HALTED: begin
          if (start) begin
            if (halt_req)       state_d = HALTED;
            else if (!misalign) state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: fetch only in FETCH, never on a halt or redirect cycle, and
  // only when the queue has (or is freeing) a slot.
  always_comb begin
    busy  = (state_q == FETCH);
    flush = redirect_valid;
    push  = busy && !halt_req && !redirect_valid && (!q_full || pop);
  end

  // Next fetch PC: aligned redirect target, else advance past a pushed word.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      if (!trap) pc_d = redirect_target & ~ADDR_W'(3);
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_pc_i   (pc_q),
    .push_word_i (imem_data),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (q_count),
    .head_pc_o   (inst_pc),
    .head_word_o (inst_out)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a random
// run, all compared against a queue-based behavioural model of the fetch rules.
module tb_fetch_controller;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, halt_req = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [7:0]  redirect_target = 8'd0;
  logic [7:0]  imem_addr, inst_pc;
  logic [31:0] imem_data, inst_out;
  logic        inst_valid, busy, misalign;

  // second instance exercising a non-zero reset PC
  logic        start2 = 1'b0, halt2 = 1'b0, rv2 = 1'b0, ready2 = 1'b1;
  logic [7:0]  rt2 = 8'd0;
  logic [7:0]  imem_addr2, inst_pc2;
  logic [31:0] imem_data2, inst_out2;
  logic        inst_valid2, busy2, misalign2;

  logic [7:0]  rom [256];

  int checks = 0;
  int errors = 0;

  // behavioural model: 0 idle, 1 fetching, 2 halted
  int          mst;
  logic [7:0]  mpc;
  bit          mmis;
  logic [7:0]  qpc[$];
  logic [31:0] qw[$];

  logic [50:0] act;
  assign act = {inst_valid, inst_out, inst_pc, imem_addr, busy, misalign};

  assign imem_data  = {rom[imem_addr], rom[imem_addr + 8'd1], rom[imem_addr + 8'd2], rom[imem_addr + 8'd3]};
  assign imem_data2 = {rom[imem_addr2], rom[imem_addr2 + 8'd1], rom[imem_addr2 + 8'd2], rom[imem_addr2 + 8'd3]};

  always #5 clk = ~clk;

  fetch_controller #(.ADDR_W(8), .RESET_PC(8'h00), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_data(imem_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .busy(busy), .misalign(misalign)
  );

  fetch_controller #(.ADDR_W(8), .RESET_PC(8'hF8), .QDEPTH(QD)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .halt_req(halt2),
    .redirect_valid(rv2), .redirect_target(rt2),
    .imem_addr(imem_addr2), .imem_data(imem_data2), .inst_valid(inst_valid2),
    .inst_ready(ready2), .inst_out(inst_out2), .inst_pc(inst_pc2),
    .busy(busy2), .misalign(misalign2)
  );

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    return {rom[a], rom[a1], rom[a2], rom[a3]};
  endfunction

  task automatic set_word(input logic [7:0] a, input logic [31:0] w);
    rom[a] = w[31:24]; rom[a + 8'd1] = w[23:16]; rom[a + 8'd2] = w[15:8]; rom[a + 8'd3] = w[7:0];
  endtask

  function automatic logic [50:0] mexp();
    logic v; logic [31:0] w; logic [7:0] p;
    v = (qpc.size() != 0);
    w = v ? qw[0] : 32'd0;
    p = v ? qpc[0] : 8'd0;
    return {v, w, p, mpc, (mst == 1), mmis};
  endfunction

  task automatic model_reset();
    mst = 0; mpc = 8'h00; mmis = 0;
    qpc.delete(); qw.delete();
  endtask

  // one clock edge of the fetch rules, using the inputs currently driven
  task automatic model_step();
    int n; bit pop, trap;
    n = qpc.size();
    pop = (n != 0) && inst_ready;
    trap = 0;
`ifdef FETCH_ALIGN_TRAP_EN
    trap = redirect_valid && (redirect_target % 4 != 0);
`endif
    if (redirect_valid) begin
      qpc.delete(); qw.delete();
      if (trap) mmis = 1;
      else      mpc = redirect_target - (redirect_target % 4);
    end else begin
      if (pop) begin void'(qpc.pop_front()); void'(qw.pop_front()); end
      if (mst == 1 && !halt_req && (n < QD || pop)) begin
        qpc.push_back(mpc); qw.push_back(word_at(mpc));
        mpc = mpc + 8'd4;
      end
    end
    if (trap) mst = 2;
    else if (mst == 1) begin
      if (halt_req) mst = 2;
    end else if (start) begin
      if (halt_req) mst = 2;
      else if (!mmis) mst = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; halt_req = 0; redirect_valid = 0; redirect_target = 0; inst_ready = 0; start2 = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    if (act !== 51'd0) begin
      errors++; $display("FAIL reset_zero got %h exp %h", act, 51'd0);
    end
    checks++;
    if (act !== mexp()) begin
      errors++; $display("FAIL reset_model got %h exp %h", act, mexp());
    end
    checks++;
    if (imem_addr2 !== 8'hF8) begin
      errors++; $display("FAIL reset_pc2 got %h exp f8", imem_addr2);
    end
    checks++;
    rst_n = 1;
  endtask

  task automatic test_basic();
    logic [31:0] w[3];
    w[0] = 32'hA0A1A2A3; w[1] = 32'hB0B1B2B3; w[2] = 32'hC0C1C2C3;
    for (int i = 0; i < 3; i++) set_word(8'(i * 4), w[i]);
    do_reset();
    inst_ready = 1; start = 1;
    tick();
    start = 0;
    if (act !== mexp()) begin errors++; $display("FAIL basic_first got %h exp %h", act, mexp()); end
    checks++;
    tick();
    for (int i = 0; i < 3; i++) begin
      if ({inst_valid, inst_out, inst_pc} !== {1'b1, w[i], 8'(i * 4)}) begin
        errors++; $display("FAIL basic_seq%0d got v%b %h pc %h exp %h pc %h", i, inst_valid, inst_out, inst_pc, w[i], 8'(i * 4));
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    inst_ready = 0; start = 1;
    tick();
    start = 0;
    repeat (5) begin
      tick();
      if (act !== mexp()) begin errors++; $display("FAIL stall_model got %h exp %h", act, mexp()); end
      checks++;
    end
    if ({inst_valid, imem_addr, inst_pc} !== {1'b1, 8'h08, 8'h00}) begin
      errors++; $display("FAIL stall_full got v%b addr %h pc %h exp v1 addr 08 pc 00", inst_valid, imem_addr, inst_pc);
    end
    checks++;
    inst_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if ({inst_valid, inst_out, inst_pc} !== {1'b1, word_at(8'(i * 4)), 8'(i * 4)}) begin
        errors++; $display("FAIL stall_resume%0d got v%b %h pc %h exp %h pc %h", i, inst_valid, inst_out, inst_pc, word_at(8'(i * 4)), 8'(i * 4));
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    inst_ready = 0; start = 1;
    tick();
    start = 0;
    tick(); tick();
    inst_ready = 1; redirect_valid = 1; redirect_target = 8'h40;
    tick();
    redirect_valid = 0;
    if ({inst_valid, imem_addr} !== {1'b0, 8'h40}) begin
      errors++; $display("FAIL redirect_bubble got v%b addr %h exp v0 addr 40", inst_valid, imem_addr);
    end
    checks++;
    tick();
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 8'h40, word_at(8'h40)}) begin
      errors++; $display("FAIL redirect_target got v%b pc %h %h exp pc 40 %h", inst_valid, inst_pc, inst_out, word_at(8'h40));
    end
    checks++;
    if (act !== mexp()) begin errors++; $display("FAIL redirect_model got %h exp %h", act, mexp()); end
    checks++;
  endtask

  task automatic test_wrap();
    logic [7:0] p;
    do_reset();
    start2 = 1;
    tick();
    start2 = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      p = 8'hF8 + 8'(i * 4);
      if ({inst_valid2, inst_pc2, inst_out2} !== {1'b1, p, word_at(p)}) begin
        errors++; $display("FAIL wrap%0d got v%b pc %h %h exp pc %h %h", i, inst_valid2, inst_pc2, inst_out2, p, word_at(p));
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_halt();
    do_reset();
    inst_ready = 1; start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    repeat (3) begin
      tick();
      if (act !== mexp()) begin errors++; $display("FAIL halt_model got %h exp %h", act, mexp()); end
      checks++;
    end
    if ({busy, inst_valid, imem_addr} !== {1'b0, 1'b0, 8'h10}) begin
      errors++; $display("FAIL halt_drained got busy %b v%b addr %h exp busy 0 v0 addr 10", busy, inst_valid, imem_addr);
    end
    checks++;
    start = 1;
    tick();
    start = 0;
    tick();
    if ({inst_valid, inst_pc, busy} !== {1'b1, 8'h10, 1'b1}) begin
      errors++; $display("FAIL halt_resume got v%b pc %h busy %b exp v1 pc 10 busy 1", inst_valid, inst_pc, busy);
    end
    checks++;
  endtask

  task automatic test_misalign();
    do_reset();
    inst_ready = 1; start = 1;
    tick();
    start = 0;
    tick(); tick();
    redirect_valid = 1; redirect_target = 8'h41;
    tick();
    redirect_valid = 0;
`ifdef FETCH_ALIGN_TRAP_EN
    if ({misalign, busy, inst_valid, imem_addr} !== {3'b100, 8'h08}) begin
      errors++; $display("FAIL misalign_trap got mis %b busy %b v%b addr %h exp 1 0 0 addr 08", misalign, busy, inst_valid, imem_addr);
    end
    checks++;
    start = 1;
    tick();
    start = 0;
    tick();
    if ({misalign, busy, inst_valid} !== 3'b100) begin
      errors++; $display("FAIL misalign_start got mis %b busy %b v%b exp 1 0 0", misalign, busy, inst_valid);
    end
    checks++;
`else
    if ({misalign, inst_valid, imem_addr} !== {2'b00, 8'h40}) begin
      errors++; $display("FAIL misalign_clear got mis %b v%b addr %h exp 0 0 addr 40", misalign, inst_valid, imem_addr);
    end
    checks++;
    tick();
    if ({misalign, inst_valid, inst_pc} !== {2'b01, 8'h40}) begin
      errors++; $display("FAIL misalign_fetch got mis %b v%b pc %h exp 0 1 pc 40", misalign, inst_valid, inst_pc);
    end
    checks++;
`endif
    if (act !== mexp()) begin errors++; $display("FAIL misalign_model got %h exp %h", act, mexp()); end
    checks++;
  endtask

  task automatic test_async_reset();
    do_reset();
    inst_ready = 1; start = 1;
    tick();
    start = 0;
    tick(); tick();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    if ({act, imem_addr2} !== {51'd0, 8'hF8}) begin
      errors++; $display("FAIL async_reset got %h addr2 %h exp 0 addr2 f8", act, imem_addr2);
    end
    checks++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    logic [7:0] t;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      inst_ready     = ($urandom_range(0, 3) != 0);
      start          = ($urandom_range(0, 7) == 0);
      halt_req       = ($urandom_range(0, 15) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      t = 8'($urandom);
      if ($urandom_range(0, 7) != 0) t = t & 8'hFC;
      redirect_target = t;
      tick();
      if (act !== mexp()) begin
        errors++; $display("FAIL random%0d got %h exp %h", i, act, mexp());
      end
      checks++;
    end
    start = 0; halt_req = 0; redirect_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_misalign();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
